// File: rtl/bram_arbiter_pkg.sv
// ============================================================================
// Module      : bram_arbiter_pkg
// Description : Shared Kyber BRAM parameters. Holds the coefficient bank
//               width/depth constants, the requester-id encoding used by the
//               bank arbiter, the registered read-tag type and small helpers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bram_arbiter_pkg;

    // Coefficient bank geometry: one 12-bit coefficient per word, 16 words.
    localparam int BRAM_DW = 12;
    localparam int BRAM_AW = 4;

    // Requester identities. The encoding doubles as the priority-pointer
    // value, so prio == REQ_HOST means the host wins a contested cycle.
    typedef enum logic {
        REQ_HOST = 1'b0,   // load/unload host
        REQ_PE   = 1'b1    // PE datapath
    } req_id_e;

    // Read-return tag captured when a read is granted; it steers the bank
    // output to the issuing requester one cycle later.
    typedef struct packed {
        logic    valid;
        req_id_e id;
    } rd_tag_t;

    // The requester that is not 'id'.
    function automatic req_id_e other_req(input req_id_e id);
        return (id == REQ_HOST) ? REQ_PE : REQ_HOST;
    endfunction

    // Priority after a granted cycle: a locked winner keeps priority,
    // otherwise priority passes to the other requester.
    function automatic req_id_e prio_after_grant(input req_id_e winner,
                                                 input logic    lock);
        return lock ? winner : other_req(winner);
    endfunction

endpackage : bram_arbiter_pkg

`default_nettype wire

// File: rtl/bram_arbiter.sv
// ============================================================================
// Module      : bram_arbiter
// Description : Two-requester arbiter in front of a single-port-per-direction
//               coefficient bank (write port + read port, read latency 1).
//               One access is granted per cycle; the grant is combinational
//               and the access is issued to the bank in the same cycle.
//               Read data returns one cycle later, routed by a registered tag.
// Ports       :
//   clk, reset                 - clock, asynchronous active-high reset
//   req0/1, we0/1              - request and write/read select per requester
//   addr0/1, wdata0/1          - access address and write data
//   lock0/1                    - winner keeps priority for the next cycle
//   gnt0/1                     - combinational grant (at most one high)
//   rvalid0/1, rdata0/1        - read return (rdata is 0 when rvalid is 0)
//   bram_wen/waddr/din         - bank write port
//   bram_raddr, bram_dout      - bank read port (dout valid 1 cycle later)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bram_arbiter
    import bram_arbiter_pkg::*;
#(
    parameter int DW = BRAM_DW,
    parameter int AW = BRAM_AW
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    input  logic          lock0,

    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    input  logic          lock1,

    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,

    output logic          bram_wen,
    output logic [AW-1:0] bram_waddr,
    output logic [AW-1:0] bram_raddr,
    output logic [DW-1:0] bram_din,
    input  logic [DW-1:0] bram_dout
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    req_id_e       prio;        // requester that wins a contested cycle
    req_id_e       prio_next;
    rd_tag_t       rd_tag;      // owner of the read data arriving this cycle

    // ------------------------------------------------------------------
    // Grant decision
    // ------------------------------------------------------------------
    logic          gnt_any;
    req_id_e       gnt_id;

    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = REQ_HOST;
        // Reset blanks the grant so nothing reaches the bank while the
        // read tag is being cleared.
        if (!reset) begin
            unique case ({req1, req0})
                2'b11: begin
                    gnt_any = 1'b1;
                    gnt_id  = prio;
                end
                2'b01: begin
                    gnt_any = 1'b1;
                    gnt_id  = REQ_HOST;
                end
                2'b10: begin
                    gnt_any = 1'b1;
                    gnt_id  = REQ_PE;
                end
                default: begin
                    gnt_any = 1'b0;
                    gnt_id  = REQ_HOST;
                end
            endcase
        end
    end

    assign gnt0 = gnt_any && (gnt_id == REQ_HOST);
    assign gnt1 = gnt_any && (gnt_id == REQ_PE);

    // ------------------------------------------------------------------
    // Winner's access fields
    // ------------------------------------------------------------------
    logic          sel_we;
    logic          sel_lock;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    always_comb begin
        if (gnt_id == REQ_PE) begin
            sel_we    = we1;
            sel_lock  = lock1;
            sel_addr  = addr1;
            sel_wdata = wdata1;
        end else begin
            sel_we    = we0;
            sel_lock  = lock0;
            sel_addr  = addr0;
            sel_wdata = wdata0;
        end
    end

    logic          do_write;
    logic          do_read;

    assign do_write = gnt_any &&  sel_we;
    assign do_read  = gnt_any && !sel_we;

    // Bank ports are zeroed when idle so the bank sees a quiet bus and
    // downstream observers never latch stale addresses or data.
    assign bram_wen   = do_write;
    assign bram_waddr = do_write ? sel_addr  : '0;
    assign bram_din   = do_write ? sel_wdata : '0;
    assign bram_raddr = do_read  ? sel_addr  : '0;

    // ------------------------------------------------------------------
    // Priority pointer update
    // ------------------------------------------------------------------
    always_comb begin
        prio_next = prio;
        if (gnt_any) begin
            prio_next = prio_after_grant(gnt_id, sel_lock);
        end
    end

    // ------------------------------------------------------------------
    // Registered state: priority pointer and read-return tag
    // ------------------------------------------------------------------
    // The asynchronous clear drops a tag captured on the edge where reset
    // rises, so an in-flight read never produces an rvalid pulse after
    // reset is released.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio   <= REQ_HOST;
            rd_tag <= '0;
        end else begin
            prio         <= prio_next;
            rd_tag.valid <= do_read;
            rd_tag.id    <= gnt_id;
        end
    end

    // ------------------------------------------------------------------
    // Read return routing
    // ------------------------------------------------------------------
    assign rvalid0 = rd_tag.valid && (rd_tag.id == REQ_HOST);
    assign rvalid1 = rd_tag.valid && (rd_tag.id == REQ_PE);
    assign rdata0  = rvalid0 ? bram_dout : '0;
    assign rdata1  = rvalid1 ? bram_dout : '0;

endmodule : bram_arbiter

`default_nettype wire

// File: doc/bram_arbiter.md
BRAM_ARBITER -- requirements
Module: bram_arbiter

Interface
REQ-001 Parameter: DW, 12, data width of one coefficient word.
REQ-002 Parameter: AW, 4, address width; bank depth is 2^AW = 16 words.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req0 / req1  input  1  access request from requester 0 (load/unload host) and requester 1 (PE datapath).
REQ-006 we0 / we1  input  1  1 = write access, 0 = read access; qualified by reqN.
REQ-007 addr0 / addr1  input  AW  word address of the access.
REQ-008 wdata0 / wdata1  input  DW  write data.
REQ-009 lock0 / lock1  input  1  when granted, the requester keeps priority in the next cycle.
REQ-010 gnt0 / gnt1  output  1  combinational grant; the access is performed in the same cycle.
REQ-011 rvalid0 / rvalid1  output  1  registered pulse marking read data for that requester.
REQ-012 rdata0 / rdata1  output  DW  read data; equals bram_dout while rvalidN = 1, 0 otherwise.
REQ-013 bram_wen  output  1  write enable to the bank.
REQ-014 bram_waddr / bram_raddr  output  AW  bank write and read addresses.
REQ-015 bram_din  output  DW  bank write data.
REQ-016 bram_dout  input  DW  bank read data, valid one cycle after bram_raddr is presented.

Function
REQ-017 At most one of gnt0/gnt1 SHALL be 1 in any cycle; gntN SHALL be 0 whenever reqN = 0 or reset = 1.
REQ-018 A 1-bit registered priority pointer prio SHALL select the winner:
- Both requesting: grant requester prio.
- Only one requesting: grant that requester, regardless of prio.
REQ-019 After a granted cycle, prio SHALL become the other requester, except when the granted requester's lockN = 1; then prio SHALL point to the granted requester.
REQ-020 With no grant in a cycle, prio SHALL hold.
REQ-021 Granted write: bram_wen = 1, bram_waddr = addrN, bram_din = wdataN, all in the same cycle.
REQ-022 Granted read: bram_raddr = addrN in the same cycle; rvalidN SHALL be 1 exactly one cycle later (fixed latency 1).
REQ-023 With no grant or a granted write: bram_wen = 0 except for the write; bram_waddr, bram_raddr and bram_din SHALL be driven to 0 when not in use.
REQ-024 Read routing SHALL use a registered tag (valid bit + requester id) captured at grant time, so back-to-back reads from alternating requesters each return to the correct requester.
REQ-025 A read the cycle after a write to the same address SHALL return the new data, because the bank has write-then-read ordering across cycles. Same-cycle read/write collision is impossible because only one grant is given per cycle.
REQ-026 Throughput: with both requesters continuously requesting and no lock, grants SHALL alternate every cycle; maximum wait is 1 cycle.
REQ-027 A held lock SHALL starve the other requester for as long as it is held; this is a permitted, caller-controlled behaviour.

Reset
REQ-028 Asserting reset SHALL immediately set:
- prio = 0
- read tag valid = 0
- rvalid0 = rvalid1 = 0, rdata0 = rdata1 = 0
- gnt0 = gnt1 = 0, bram_wen = 0
REQ-029 A read granted in the cycle reset asserts SHALL be discarded: no rvalid pulse after reset deasserts.
REQ-030 On the first cycle after reset deasserts, with both requests active, requester 0 SHALL win.

Structure
REQ-031 DW, AW and the requester-id encoding (0 = host, 1 = PE) SHALL live in the shared Kyber parameter package, next to the existing BRAM width constants.
REQ-032 No sub-module is required. The bank is instantiated outside this block, so several arbiters can share one bank-level wrapper.

Verification
REQ-033 Reset, then req0 write addr=3 data=0x0A5 alone -> gnt0 = 1, bram_wen = 1, bram_waddr = 3, bram_din = 0x0A5, gnt1 = 0.
REQ-034 req0 and req1 both read continuously (addr 1 and 2, bank holds 0x111 and 0x222), no lock -> gnt toggles 0,1,0,1. rvalid0 carries 0x111 and rvalid1 carries 0x222 one cycle after each respective grant.
REQ-035 req1 holds lock1 = 1 with both requesting for 4 cycles -> gnt1 = 1 all 4 cycles. lock1 drops -> gnt1 for that cycle, then gnt0 next.
REQ-036 req0 write addr=5 data=0xD01 in cycle n, req1 read addr=5 in cycle n+1 -> rvalid1 = 1 in cycle n+2 with rdata1 = 0xD01.
REQ-037 Grant a read to req1, assert reset the next cycle -> rvalid1 stays 0 through and after reset, prio = 0, first contested grant goes to requester 0.
REQ-038 Random req/we/lock for 10k cycles -> scoreboard shows: never two grants in one cycle; every read returns the model bank value to the issuing requester exactly 1 cycle later.
